// File: rtl/pipe_skid_reg32.sv
// Two-entry skid buffer: registered output stage plus one skid word.
// Every output is a flop, so upstream and downstream timing stay decoupled.
module pipe_skid_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] OutData,
    input  logic             OutReady,
    output logic [1:0]       Count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_count;
    logic [1:0]       w_count;
    logic             w_accept;
    logic             w_consume;

    assign w_accept  = InValid & r_in_ready;
    assign w_consume = r_out_valid & OutReady;

    // Next-state and next-data selection; an emptied register is zeroed.
    always_comb begin
        w_state = r_state;
        w_out   = r_out;
        w_skid  = r_skid;
        if (Flush) begin
            w_state = S_EMPTY;
            w_out   = '0;
            w_skid  = '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_out   = InData;
                        w_state = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        w_out = InData;
                    end else if (w_accept) begin
                        w_skid  = InData;
                        w_state = S_FULL;
                    end else if (w_consume) begin
                        w_out   = '0;
                        w_state = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_consume) begin
                        w_out   = r_skid;
                        w_skid  = '0;
                        w_state = S_ONE;
                    end
                end
                default: begin
                    w_state = S_EMPTY;
                    w_out   = '0;
                    w_skid  = '0;
                end
            endcase
        end
    end

    // Occupancy for the next state, registered alongside it.
    always_comb begin
        w_count = 2'd0;
        unique case (w_state)
            S_ONE:   w_count = 2'd1;
            S_FULL:  w_count = 2'd2;
            default: w_count = 2'd0;
        endcase
    end

    // State, data and status flops; status decoded from next state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_EMPTY;
            r_out       <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_out       <= w_out;
            r_skid      <= w_skid;
            r_in_ready  <= (w_state != S_FULL);
            r_out_valid <= (w_state != S_EMPTY);
            r_count     <= w_count;
        end
    end

    assign InReady  = r_in_ready;
    assign OutValid = r_out_valid;
    assign OutData  = r_out;
    assign Count    = r_count;

endmodule

// File: tb/tb_pipe_skid_reg32.sv
// Bench for pipe_skid_reg32: directed cases then random traffic,
// compared against a bounded-queue model of the buffer.
module tb_pipe_skid_reg32;

    logic        Clk;
    logic        Rst;
    logic        Flush;
    logic        InValid;
    logic [31:0] InData;
    logic        InReady;
    logic        OutValid;
    logic [31:0] OutData;
    logic        OutReady;
    logic [1:0]  Count;

    int n_tests;
    int n_fail;

    logic [31:0] q[$];

    pipe_skid_reg32 #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Flush    (Flush),
        .InValid  (InValid),
        .InData   (InData),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutReady (OutReady),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 32'h0;
        check({tag, ".cnt"}, 32'(Count), 32'(q.size()));
        check({tag, ".ovld"}, 32'(OutValid), 32'(q.size() != 0));
        check({tag, ".irdy"}, 32'(InReady), 32'(q.size() < 2));
        check({tag, ".data"}, OutData, exp_data);
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic step(input logic iv, input logic [31:0] id,
                        input logic ordy, input logic fl,
                        input string tag);
        bit can_acc;
        bit can_con;
        InValid  = iv;
        InData   = id;
        OutReady = ordy;
        Flush    = fl;
        can_acc  = iv && (q.size() < 2);
        can_con  = ordy && (q.size() != 0);
        @(posedge Clk);
        if (fl) begin
            q.delete();
        end else begin
            if (can_con) void'(q.pop_front());
            if (can_acc) q.push_back(id);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        InData   = 32'h0;
        OutReady = 1'b0;
        Rst      = 1'b1;
        #1 Rst   = 1'b0;
        #2;
        check_all("reset");
        @(posedge Clk);
        #1 Rst = 1'b1;

        // Single word, one-cycle latency.
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "single");
        step(1'b0, 32'h0, 1'b1, 1'b0, "single_drain");

        // Backpressure into FULL, third word refused, then drain.
        step(1'b1, 32'h11111111, 1'b0, 1'b0, "bp1");
        step(1'b1, 32'h22222222, 1'b0, 1'b0, "bp2");
        step(1'b1, 32'h33333333, 1'b0, 1'b0, "bp3_refused");
        step(1'b0, 32'h0, 1'b1, 1'b0, "bp_out1");
        step(1'b0, 32'h0, 1'b1, 1'b0, "bp_out2");

        // Streaming: one word per cycle.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0, "stream");
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, "stream_drain");

        // Flush from FULL wins over accept and consume.
        step(1'b1, 32'hA, 1'b0, 1'b0, "fl_a");
        step(1'b1, 32'hB, 1'b0, 1'b0, "fl_b");
        step(1'b1, 32'hC, 1'b1, 1'b1, "flush");
        step(1'b0, 32'h0, 1'b1, 1'b0, "post_flush");

        // Asynchronous reset mid-operation, between edges.
        step(1'b1, 32'h55, 1'b0, 1'b0, "ar1");
        step(1'b1, 32'h66, 1'b0, 1'b0, "ar2");
        InValid = 1'b0;
        #2 Rst = 1'b0;
        #1;
        q.delete();
        check_all("async_rst");
        #2 Rst = 1'b1;
        step(1'b1, 32'h77, 1'b0, 1'b0, "first_after_rst");
        step(1'b0, 32'h0, 1'b1, 1'b0, "after_rst_drain");

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
